// File: rtl/spi_target.sv
// SPI configuration target: oversamples SCLK/SEN/SDI/SLD on BUS_CLK, shifts a WIDTH-bit word, commits it on SLD.
// Pin edge to register update is SYNC_STAGES+1 cycles; no backpressure, SDO is registered from the shift MSB.
module spi_target #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LD_TIMEOUT  = 255
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  input  logic             SCLK,
  input  logic             SEN,
  input  logic             SDI,
  input  logic             SLD,
  output logic             SDO,
  input  logic [WIDTH-1:0] READBACK,
  output logic [WIDTH-1:0] CONF_OUT,
  output logic             CONF_VALID,
  output logic             LD_ERR,
  output logic [15:0]      BIT_CNT
);

  localparam int TW = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIMED   = PW'(SYNC_STAGES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LD_TIMEOUT - 1);
  localparam logic [15:0]   FULL_CNT = 16'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_LD = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] sld_sync_q, sld_sync_d;
  logic [2:0]             dly_q, dly_d;
  logic [PW-1:0]          prime_q, prime_d;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       sreg_q, sreg_d;
  logic [WIDTH-1:0]       conf_q, conf_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   sdo_q, sdo_d;

  logic primed;
  logic sclk_s, sen_s, sdi_s, sld_s;
  logic sclk_rise, sen_rise, sen_fall, sld_rise;

  // Edges are masked until the synchronizer and delay flops hold only post-reset
  // samples, so a SEN already high at reset release never looks like a fresh rise.
  assign primed    = (prime_q == PRIMED);
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sen_s     = sen_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sld_s     = sld_sync_q[SYNC_STAGES-1];
  assign sclk_rise = primed &  sclk_s & ~dly_q[0];
  assign sen_rise  = primed &  sen_s  & ~dly_q[1];
  assign sen_fall  = primed & ~sen_s  &  dly_q[1];
  assign sld_rise  = primed &  sld_s  & ~dly_q[2];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    sen_sync_d  = {sen_sync_q[SYNC_STAGES-2:0], SEN};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], SDI};
    sld_sync_d  = {sld_sync_q[SYNC_STAGES-2:0], SLD};
    dly_d       = {sld_s, sen_s, sclk_s};
    prime_d     = primed ? prime_q : prime_q + PW'(1);

    state_d = state_q;
    sreg_d  = sreg_q;
    conf_d  = conf_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sen_rise) begin
          sreg_d  = READBACK;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A shift coinciding with the SEN fall still lands before WAIT_LD.
        if (sclk_rise) begin
          sreg_d = {sreg_q[WIDTH-2:0], sdi_s};
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
        if (sen_fall) begin
          tmo_d   = '0;
          state_d = WAIT_LD;
        end
      end
      WAIT_LD: begin
        if (sen_rise) begin
          err_d   = 1'b1;
          sreg_d  = READBACK;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (sld_rise) begin
          if (cnt_q == FULL_CNT) begin
            conf_d = sreg_q;
            vld_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    sdo_d = (state_q != IDLE) & sreg_q[WIDTH-1];
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      sclk_sync_q <= '0;
      sen_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sld_sync_q  <= '0;
      dly_q       <= '0;
      prime_q     <= '0;
      state_q     <= IDLE;
      sreg_q      <= '0;
      conf_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
      sdo_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sen_sync_q  <= sen_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sld_sync_q  <= sld_sync_d;
      dly_q       <= dly_d;
      prime_q     <= prime_d;
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      conf_q      <= conf_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      sdo_q       <= sdo_d;
    end
  end

  assign SDO        = sdo_q;
  assign CONF_OUT   = conf_q;
  assign CONF_VALID = vld_q;
  assign LD_ERR     = err_q;
  assign BIT_CNT    = cnt_q;

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter WIDTH, default 16: length of the configuration shift register in bits (range 2..1024).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on all serial inputs (range 2..4).
REQ-003 SHALL have parameter LD_TIMEOUT, default 255: BUS_CLK cycles allowed between SEN deassert and SLD.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: the clock port is BUS_CLK and the reset port is BUS_RST.
REQ-005 SHALL have BUS_CLK input, width 1: the only clock, at least 4x the SCLK frequency.
REQ-006 SHALL have BUS_RST input, width 1: asynchronous active-high reset.
REQ-007 SHALL have SCLK input, width 1: serial clock from the SPI master, asynchronous to BUS_CLK.
REQ-008 SHALL have SEN input, width 1: frame enable, high while a frame is active.
REQ-009 SHALL have SDI input, width 1: serial data from the master, MSB first.
REQ-010 SHALL have SLD input, width 1: load strobe, which the master issues after SEN falls.
REQ-011 SHALL have SDO output, width 1: serial readback data to the master, registered.
REQ-012 SHALL have READBACK input, width WIDTH: parallel word shifted out on SDO during a frame.
REQ-013 SHALL have CONF_OUT output, width WIDTH: last successfully loaded configuration word, registered.
REQ-014 SHALL have CONF_VALID output, width 1: one-cycle pulse when CONF_OUT updates.
REQ-015 SHALL have LD_ERR output, width 1: one-cycle pulse when a frame is rejected.
REQ-016 SHALL have BIT_CNT output, width 16: bits received in the current or last frame.

Function
REQ-017 SHALL pass SCLK, SEN, SDI and SLD through SYNC_STAGES flops, plus one extra delay flop for edge detection; SDI SHALL be delayed identically to SCLK.
REQ-018 SHALL detect a rise as last sync stage = 1 and delay flop = 0, and a fall as the inverse.
REQ-019 Latency from an input edge at the pin to the resulting register update SHALL be SYNC_STAGES+1 BUS_CLK cycles.
REQ-020 SHALL implement the states IDLE, SHIFT and WAIT_LD.
REQ-021 In IDLE, an SEN rise SHALL load sreg <= READBACK, clear BIT_CNT to 0, and go to SHIFT.
REQ-022 In SHIFT, an SCLK rise SHALL perform sreg <= {sreg[WIDTH-2:0], SDI_sync} and BIT_CNT <= BIT_CNT+1; BIT_CNT SHALL saturate at 16'hFFFF.
REQ-023 In SHIFT, an SEN fall SHALL go to WAIT_LD and clear the timeout counter.
REQ-024 If an SCLK rise and an SEN fall occur in the same cycle, the shift SHALL be applied first and the transition SHALL then be taken.
REQ-025 In WAIT_LD, an SLD rise with BIT_CNT == WIDTH SHALL set CONF_OUT <= sreg, pulse CONF_VALID, and go to IDLE.
REQ-026 In WAIT_LD, an SLD rise with BIT_CNT != WIDTH SHALL leave CONF_OUT unchanged, pulse LD_ERR, and go to IDLE.
REQ-027 In WAIT_LD, an SEN rise SHALL pulse LD_ERR (aborted frame), reload sreg, clear BIT_CNT, and go to SHIFT.
REQ-028 In WAIT_LD, when the timeout counter reaches LD_TIMEOUT, the block SHALL pulse LD_ERR and go to IDLE.
REQ-029 SHALL ignore SCLK rises in IDLE and WAIT_LD, and SHALL ignore SLD in IDLE and SHIFT.
REQ-030 SDO SHALL be registered and equal sreg[WIDTH-1] in SHIFT and WAIT_LD, and 0 in IDLE.
REQ-031 SDO SHALL update one cycle after the sreg change that feeds it.
REQ-032 SHALL never assert CONF_VALID and LD_ERR in the same cycle.
REQ-033 BIT_CNT SHALL hold its value after a frame ends, until the next SEN rise.

Reset
REQ-034 While BUS_RST = 1, all synchronizer flops SHALL be 0, state SHALL be IDLE, and sreg, CONF_OUT and BIT_CNT SHALL be 0.
REQ-035 While BUS_RST = 1, SDO, CONF_VALID and LD_ERR SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL discard the frame without any CONF_VALID or LD_ERR pulse.
REQ-037 After reset release, a frame SHALL be accepted only on a fresh SEN rise; SEN already high at release SHALL NOT start a frame.

Verification
REQ-038 Scenario: WIDTH=16, BUS_CLK 8x SCLK, 16 bits of 0xA5C3, SEN fall, then SLD -> CONF_OUT=0xA5C3, one CONF_VALID pulse, BIT_CNT=16.
REQ-039 Scenario: READBACK=0x8001 during the frame of REQ-038 -> SDO bit sequence 1,0,0,...,0,1 sampled on successive SCLK rises.
REQ-040 Scenario: 15 bits then SLD -> LD_ERR pulse, CONF_OUT unchanged at 0xA5C3, BIT_CNT=15.
REQ-041 Scenario: 20 bits of 0xFFFF0 then SLD -> LD_ERR pulse, BIT_CNT=20, CONF_OUT unchanged.
REQ-042 Scenario: SEN fall with no SLD -> LD_ERR pulse exactly LD_TIMEOUT cycles after the fall is detected, state IDLE.
REQ-043 Scenario: BUS_RST asserted after 8 bits of a frame -> SDO=0 and BIT_CNT=0 immediately, no pulses; a following full frame of 0x1234 loads correctly.
